// File: rtl/flow_speed_dir_ctl.sv
// rtl/flow_speed_dir_ctl.sv - debounced button control and step-strobe generator for the LED flow shifter
module flow_speed_dir_ctl #(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_dir,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       dir,
  output logic       clk_bps,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int CW = $clog2(BASE_PERIOD);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  // Bit order for all per-button vectors: [0] dir, [1] speed, [2] pause.
  logic [2:0]         raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         db;
  logic [2:0]         db_q;
  logic [2:0]         press;
  logic [2:0][DW-1:0] db_cnt;

  logic          dir_press;
  logic          speed_press;
  logic          pause_press;
  logic [CW-1:0] cnt;
  logic [31:0]   period;
  logic [CW-1:0] last;
  logic          terminal;

  assign raw = {btn_pause, btn_speed, btn_dir};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        // Any cycle where the synchronized level agrees with db restarts the stability window.
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = db & ~db_q;
  assign dir_press   = press[0];
  assign speed_press = press[1];
  assign pause_press = press[2];

  assign period   = 32'(BASE_PERIOD) >> speed;
  assign last     = CW'(period - 32'd1);
  assign terminal = (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir     <= 1'b0;
      speed   <= 2'd0;
      paused  <= 1'b0;
      clk_bps <= 1'b0;
      cnt     <= '0;
    end else begin
      if (dir_press)   dir    <= ~dir;
      if (speed_press) speed  <= speed + 2'd1;
      if (pause_press) paused <= ~paused;

      clk_bps <= 1'b0;
      // A speed change restarts the period; a pause landing on terminal count parks the counter there.
      if (speed_press) begin
        cnt <= '0;
      end else if (!paused) begin
        if (terminal) begin
          if (!pause_press) begin
            cnt     <= '0;
            clk_bps <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flow_speed_dir_ctl.sv
// tb/tb_flow_speed_dir_ctl.sv - randomized scoreboard bench for flow_speed_dir_ctl
module tb_flow_speed_dir_ctl;

  localparam int BP   = 16;
  localparam int DB   = 4;
  localparam int LAT  = DB + 3;
  localparam int GAP  = 2 * DB + 4;
  localparam int MAXC = 8000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_dir = 1'b0;
  logic       btn_speed = 1'b0;
  logic       btn_pause = 1'b0;
  logic       dir;
  logic       clk_bps;
  logic [1:0] speed;
  logic       paused;

  flow_speed_dir_ctl #(.BASE_PERIOD(BP), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_dir   (btn_dir),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .dir       (dir),
    .clk_bps   (clk_bps),
    .speed     (speed),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       bps;
    bit       dir;
    bit [1:0] speed;
    bit       paused;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sch_dir[MAXC];
  bit   sch_speed[MAXC];
  bit   sch_pause[MAXC];

  // Reference model: a countdown of running cycles left until the next strobe.
  bit m_dir = 1'b0;
  bit m_paused = 1'b0;
  int m_speed = 0;
  int m_left = BP;

  task automatic model_step();
    bit bps;
    bit ev_d;
    bit ev_s;
    bit ev_p;
    bps = 1'b0;
    if (rst) begin
      m_dir = 1'b0; m_speed = 0; m_paused = 1'b0; m_left = BP;
      return;
    end
    ev_d = (cyc < MAXC) ? sch_dir[cyc]   : 1'b0;
    ev_s = (cyc < MAXC) ? sch_speed[cyc] : 1'b0;
    ev_p = (cyc < MAXC) ? sch_pause[cyc] : 1'b0;
    if (!ev_s && !m_paused && !(m_left == 1 && ev_p)) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        bps = 1'b1;
        m_left = BP >> m_speed;
      end
    end
    if (ev_d) m_dir = !m_dir;
    if (ev_s) begin
      m_speed = (m_speed + 1) % 4;
      m_left = BP >> m_speed;
    end
    if (ev_p) m_paused = !m_paused;
    if (bps || ev_d || ev_s || ev_p)
      exp_q.push_back('{cyc, bps, m_dir, 2'(m_speed), m_paused});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // Monitor: every strobe and every control change must match a queued expectation.
  initial begin
    rec_t e;
    bit   seen;
    forever begin
      @(negedge clk);
      seen = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc || clk_bps !== e.bps || dir !== e.dir ||
            speed !== e.speed || paused !== e.paused) begin
          errors++;
          $display("FAIL scoreboard at cyc %0d: got bps=%b dir=%b speed=%0d paused=%b, expected (cyc %0d) bps=%b dir=%b speed=%0d paused=%b",
                   cyc, clk_bps, dir, speed, paused, e.cyc, e.bps, e.dir, e.speed, e.paused);
        end
        if (e.bps) seen = 1'b1;
      end
      if (clk_bps !== 1'b0 && !seen) begin
        checks++;
        errors++;
        $display("FAIL unexpected strobe at cyc %0d: got clk_bps=%b expected 0", cyc, clk_bps);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (clk_bps !== 1'b1 && k < 100);
  endtask

  // Raw levels set at a negedge rise before the next edge; an accepted press acts LAT edges later.
  task automatic start_press(input bit d, input bit s, input bit p);
    if (cyc + LAT < MAXC) begin
      if (d) sch_dir[cyc + LAT]   = 1'b1;
      if (s) sch_speed[cyc + LAT] = 1'b1;
      if (p) sch_pause[cyc + LAT] = 1'b1;
    end
    btn_dir = d; btn_speed = s; btn_pause = p;
  endtask

  task automatic release_btns();
    btn_dir = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic press(input bit d, input bit s, input bit p, input int hold);
    if (hold >= DB) start_press(d, s, p);
    else begin
      btn_dir = d; btn_speed = s; btn_pause = p;
    end
    repeat (hold) @(negedge clk);
    release_btns();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int strobes;
    int m;
    int sel;
    bit want_dir;

    // T1: reset state and first strobe one full period after release
    repeat (2) @(negedge clk);
    check("reset dir", dir, 0);
    check("reset clk_bps", clk_bps, 0);
    check("reset speed", speed, 0);
    check("reset paused", paused, 0);
    #2 rst = 1'b0;
    wait_strobe(k);
    check("first strobe after reset", k, BP);

    // T3: short glitch ignored, held press toggles at edge LAT
    btn_dir = 1'b1;
    repeat (DB - 1) @(negedge clk);
    btn_dir = 1'b0;
    repeat (GAP) @(negedge clk);
    check("glitch leaves dir", dir, 0);
    start_press(1'b1, 1'b0, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    check("dir before edge 7", dir, 0);
    @(negedge clk);
    check("dir at edge 7", dir, 1);
    repeat (10 - LAT) @(negedge clk);
    release_btns();

    // T2/T4: strobe spacing at each rate, speed wraps 3 -> 0
    for (int s = 0; s < 4; s++) begin
      wait_strobe(k);
      wait_strobe(k);
      check($sformatf("spacing at speed %0d", s), k, BP >> s);
      press(1'b0, 1'b1, 1'b0, DB + 1);
      check($sformatf("speed after press %0d", s + 1), speed, (s + 1) % 4);
    end

    // T5: pause holds the count, resume continues from the held phase
    wait_strobe(k);
    start_press(1'b0, 1'b0, 1'b1);
    repeat (DB + 1) @(negedge clk);
    btn_pause = 1'b0;
    strobes = 0;
    repeat (50) begin
      @(negedge clk);
      if (clk_bps === 1'b1) strobes++;
    end
    check("no strobes while paused", strobes, 0);
    check("paused flag", paused, 1);
    m = cyc;
    start_press(1'b0, 1'b0, 1'b1);
    repeat (DB + 1) @(negedge clk);
    btn_pause = 1'b0;
    wait_strobe(k);
    // Paused at edge S+LAT with LAT cycles already counted, so BP-LAT remain after the resume edge.
    check("strobe after resume", cyc, m + LAT + (BP - LAT));
    repeat (GAP) @(negedge clk);

    // T6a: dir press landing on a strobe edge
    wait_strobe(k);
    repeat (BP - LAT) @(negedge clk);
    want_dir = !m_dir;
    start_press(1'b1, 1'b0, 1'b0);
    repeat (LAT) @(negedge clk);
    check("collision strobe", clk_bps, 1);
    check("collision new dir", dir, want_dir);
    release_btns();

    // T6b: speed press on terminal count suppresses the strobe and restarts
    wait_strobe(k);
    repeat (BP - LAT) @(negedge clk);
    start_press(1'b0, 1'b1, 1'b0);
    repeat (LAT) @(negedge clk);
    check("terminal speed press no strobe", clk_bps, 0);
    check("terminal speed press speed", speed, 1);
    btn_speed = 1'b0;
    wait_strobe(k);
    check("restart period after speed press", k, BP >> 1);
    repeat (GAP) @(negedge clk);

    // Randomized presses, glitches and idles checked by the scoreboard
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end else begin
        m = $urandom_range(1, 7);
        if ($urandom_range(0, 3) == 0)
          press(m[0], m[1], m[2], $urandom_range(1, DB - 1));
        else
          press(m[0], m[1], m[2], $urandom_range(DB, DB + 6));
      end
    end

    // Reset mid-count after activity
    press(1'b1, 1'b1, 1'b0, DB + 2);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-count reset dir", dir, 0);
    check("mid-count reset clk_bps", clk_bps, 0);
    check("mid-count reset speed", speed, 0);
    check("mid-count reset paused", paused, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_strobe(k);
    check("first strobe after mid-count reset", k, BP);
    repeat (20) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
